// File: rtl/keypad_encoder.sv
// keypad_encoder: scans a 4x4 active-low key matrix, synchronises and
// debounces the row sense lines, and turns each accepted press into a single
// command strobe (KEY / OP / EQUAL / CLR with EVENT) for the calculator core.
module keypad_encoder #(
  parameter int SCAN_DIV     = 1000,
  parameter int DEBOUNCE_CNT = 20000
) (
  input  logic       CLK,
  input  logic       RST,
  output logic [3:0] COL_OUT,
  input  logic [3:0] ROW_IN,
  output logic [3:0] KEY,
  output logic       OP,
  output logic       EQUAL,
  output logic       CLR,
  output logic       EVENT
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CNT);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [SW-1:0] SCAN_ONE  = SW'(1);
  // The sample cycle (or first all-high cycle) is already one stable cycle,
  // so the counter leaves one step early to keep the window DEBOUNCE_CNT long.
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CNT - 2);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1);

  typedef enum logic [1:0] {
    SCAN      = 2'd0,
    DEB_PRESS = 2'd1,
    EMIT      = 2'd2,
    WAIT_REL  = 2'd3
  } state_t;

  // True when exactly one line of an active-low pattern is low.
  function automatic logic single_low(input logic [3:0] pat);
    logic res;
    case (pat)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  // Position of the low line in a single-low pattern.
  function automatic logic [1:0] low_index(input logic [3:0] pat);
    logic [1:0] idx;
    case (pat)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Keys r2c3 and r3c3 are not wired to any command.
  function automatic logic key_mapped(input logic [1:0] r, input logic [1:0] c);
    return !((c == 2'd3) && (r[1] == 1'b1));
  endfunction

  // Next active column: the low bit moves one place left, wrapping.
  function automatic logic [3:0] rotate_col(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

  logic [3:0]    sync1_r, rs_r;
  state_t        state_r, state_n;
  logic [3:0]    col_r, col_n;
  logic [SW-1:0] scan_cnt_r, scan_cnt_n;
  logic [DW-1:0] deb_cnt_r, deb_cnt_n;
  logic [3:0]    row_lat_r, row_lat_n;
  logic [3:0]    key_r, key_n;
  logic          op_r, op_n, equal_r, equal_n, clr_r, clr_n, event_r, event_n;
  logic          press_ok_s;
  logic [1:0]    r_idx_s, c_idx_s;

  // Press qualification on the synchronised rows and decode of the latched key.
  always_comb begin
    press_ok_s = single_low(rs_r) && key_mapped(low_index(rs_r), low_index(col_r));
    r_idx_s    = low_index(row_lat_r);
    c_idx_s    = low_index(col_r);
  end

  // Next-state and next-output logic for the scan / debounce / emit FSM.
  always_comb begin
    state_n    = state_r;
    col_n      = col_r;
    scan_cnt_n = scan_cnt_r;
    deb_cnt_n  = deb_cnt_r;
    row_lat_n  = row_lat_r;
    key_n      = key_r;
    op_n       = op_r;
    equal_n    = 1'b0;
    clr_n      = 1'b0;
    event_n    = 1'b0;
    case (state_r)
      SCAN: begin
        if (scan_cnt_r == SCAN_LAST) begin
          scan_cnt_n = '0;
          if (press_ok_s) begin
            row_lat_n = rs_r;
            deb_cnt_n = '0;
            state_n   = DEB_PRESS;
          end else begin
            col_n = rotate_col(col_r);
          end
        end else begin
          scan_cnt_n = scan_cnt_r + SCAN_ONE;
        end
      end
      DEB_PRESS: begin
        if (rs_r == row_lat_r) begin
          if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_n = '0;
            state_n   = EMIT;
          end else begin
            deb_cnt_n = deb_cnt_r + DEB_ONE;
          end
        end else begin
          scan_cnt_n = '0;
          col_n      = rotate_col(col_r);
          state_n    = SCAN;
        end
      end
      EMIT: begin
        event_n   = 1'b1;
        deb_cnt_n = '0;
        state_n   = WAIT_REL;
        if ((r_idx_s != 2'd3) && (c_idx_s != 2'd3)) begin
          key_n = ({2'b00, r_idx_s} * 4'd3) + {2'b00, c_idx_s} + 4'd1;
        end else if (r_idx_s == 2'd3) begin
          key_n   = 4'd0;
          clr_n   = (c_idx_s == 2'd0);
          equal_n = (c_idx_s == 2'd2);
        end else begin
          key_n = 4'd0;
          op_n  = (r_idx_s == 2'd1);
        end
      end
      WAIT_REL: begin
        if (rs_r == 4'b1111) begin
          if (deb_cnt_r == DEB_LAST) begin
            deb_cnt_n  = '0;
            scan_cnt_n = '0;
            col_n      = rotate_col(col_r);
            state_n    = SCAN;
          end else begin
            deb_cnt_n = deb_cnt_r + DEB_ONE;
          end
        end else begin
          deb_cnt_n = '0;
        end
      end
      default: begin
        state_n    = SCAN;
        col_n      = 4'b1110;
        scan_cnt_n = '0;
        deb_cnt_n  = '0;
      end
    endcase
  end

  // State, counters, synchroniser and registered outputs, with reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1_r    <= 4'b1111;
      rs_r       <= 4'b1111;
      state_r    <= SCAN;
      col_r      <= 4'b1110;
      scan_cnt_r <= '0;
      deb_cnt_r  <= '0;
      row_lat_r  <= 4'b1111;
      key_r      <= 4'd0;
      op_r       <= 1'b0;
      equal_r    <= 1'b0;
      clr_r      <= 1'b0;
      event_r    <= 1'b0;
    end else begin
      sync1_r    <= ROW_IN;
      rs_r       <= sync1_r;
      state_r    <= state_n;
      col_r      <= col_n;
      scan_cnt_r <= scan_cnt_n;
      deb_cnt_r  <= deb_cnt_n;
      row_lat_r  <= row_lat_n;
      key_r      <= key_n;
      op_r       <= op_n;
      equal_r    <= equal_n;
      clr_r      <= clr_n;
      event_r    <= event_n;
    end
  end

  assign COL_OUT = col_r;
  assign KEY     = key_r;
  assign OP      = op_r;
  assign EQUAL   = equal_r;
  assign CLR     = clr_r;
  assign EVENT   = event_r;

endmodule

// File: tb/tb_keypad_encoder.sv
// tb_keypad_encoder: drives a modelled key matrix into keypad_encoder and
// checks every cycle against a command-level model of the keypad.
module tb_keypad_encoder;
  localparam int SCAN_DIV = 4;
  localparam int DEB      = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [3:0] COL_OUT, ROW_IN, KEY;
  logic       OP, EQUAL, CLR, EVENT;
  logic [15:0] pressed = '0;   // bit r*4+c = key at row r, column c held

  int checks = 0, errors = 0, events_seen = 0;
  int exp_q[$];                // pending command kinds: 0-9 digit, 10 '+', 11 '*', 12 '=', 13 'C'
  int held_key = 0, held_op = 0;
  int last_ev_key = 0, last_ev_op = 0, last_ev_eq = 0, last_ev_clr = 0;

  keypad_encoder #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DEB)) dut (
    .CLK(CLK), .RST(RST), .COL_OUT(COL_OUT), .ROW_IN(ROW_IN),
    .KEY(KEY), .OP(OP), .EQUAL(EQUAL), .CLR(CLR), .EVENT(EVENT)
  );

  always #5 CLK = ~CLK;

  // Key matrix: a row reads low when a held key sits on the driven column.
  always_comb begin
    for (int r = 0; r < 4; r++) ROW_IN[r] = ~|(pressed[r*4 +: 4] & ~COL_OUT);
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Command a key stands for; -1 for an unused position.
  function automatic int key_kind(input int r, input int c);
    if (r <= 2 && c <= 2) return 3 * r + c + 1;
    if (r == 3 && c == 0) return 13;
    if (r == 3 && c == 1) return 0;
    if (r == 3 && c == 2) return 12;
    if (r == 0 && c == 3) return 10;
    if (r == 1 && c == 3) return 11;
    return -1;
  endfunction

  // Per-cycle comparison of the DUT against the command model.
  task automatic compare_cycle();
    int k, ek, eo, eeq, ecl;
    if (RST == 1'b0) begin
      chk("col_single_low", $countones(~COL_OUT), 1);
      if (EVENT === 1'b1) begin
        events_seen++;
        last_ev_key = KEY; last_ev_op = OP; last_ev_eq = EQUAL; last_ev_clr = CLR;
        if (exp_q.size() == 0) begin
          chk("unexpected_event", 1, 0);
        end else begin
          k = exp_q.pop_front();
          ek = held_key; eo = held_op; eeq = 0; ecl = 0;
          if (k <= 9) ek = k;
          else if (k == 10) begin ek = 0; eo = 0; end
          else if (k == 11) begin ek = 0; eo = 1; end
          else if (k == 12) begin ek = 0; eeq = 1; end
          else begin ek = 0; ecl = 1; end
          chk("event_key", KEY, ek);
          chk("event_op", OP, eo);
          chk("event_equal", EQUAL, eeq);
          chk("event_clr", CLR, ecl);
          held_key = ek; held_op = eo;
        end
      end else begin
        chk("held_key", KEY, held_key);
        chk("held_op", OP, held_op);
        chk("equal_idle", EQUAL, 0);
        chk("clr_idle", CLR, 0);
      end
    end
  endtask

  // One clock: compare on the falling edge, return just after the rising edge.
  task automatic tick();
    @(negedge CLK);
    compare_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    pressed = '0;
    exp_q.delete();
    held_key = 0; held_op = 0;
    tick();
    RST = 1'b0;
    chk("rst_col", COL_OUT, 4'b1110);
    chk("rst_key", KEY, 0);
    chk("rst_op", OP, 0);
    chk("rst_equal", EQUAL, 0);
    chk("rst_clr", CLR, 0);
    chk("rst_event", EVENT, 0);
  endtask

  task automatic press_release(input int r, input int c, input int hold, input int rel);
    int k;
    k = key_kind(r, c);
    if (k >= 0) exp_q.push_back(k);
    pressed[r*4+c] = 1'b1;
    repeat (hold) tick();
    pressed = '0;
    repeat (rel) tick();
  endtask

  initial begin
    int ev0, n;
    logic [3:0] expc, seen;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();

    // Idle scan: columns rotate every SCAN_DIV cycles, no events.
    ev0 = events_seen;
    for (int k = 0; k < 200; k++) begin
      expc = ~(4'b0001 << ((k / SCAN_DIV) % 4));
      chk("idle_col", COL_OUT, expc);
      tick();
    end
    chk("idle_events", events_seen - ev0, 0);
    chk("idle_key", KEY, 0);
    chk("idle_op", OP, 0);

    // Clean press of digit 6.
    ev0 = events_seen;
    press_release(1, 2, 50, 50);
    chk("d6_events", events_seen - ev0, 1);
    chk("d6_key_after_release", KEY, 6);
    chk("d6_event_key", last_ev_key, 6);
    chk("d6_event_eq", last_ev_eq, 0);
    chk("d6_event_clr", last_ev_clr, 0);

    // Sequence 3 * 4 =
    ev0 = events_seen;
    press_release(0, 2, 30, 30);
    chk("seq_key3", last_ev_key, 3);
    press_release(1, 3, 30, 30);
    chk("seq_mul_key", last_ev_key, 0);
    chk("seq_mul_op", last_ev_op, 1);
    press_release(1, 0, 30, 30);
    chk("seq_key4", last_ev_key, 4);
    chk("seq_key4_op", last_ev_op, 1);
    press_release(3, 2, 30, 30);
    chk("seq_eq_key", last_ev_key, 0);
    chk("seq_eq_pulse", last_ev_eq, 1);
    chk("seq_eq_op", last_ev_op, 1);
    chk("seq_events", events_seen - ev0, 4);

    // Bounce on press and on release of r0c0.
    ev0 = events_seen;
    exp_q.push_back(key_kind(0, 0));
    for (int i = 0; i < 20; i++) begin
      pressed[0] = ((i / 3) % 2 == 0);
      tick();
    end
    pressed[0] = 1'b1;
    repeat (40) tick();
    for (int i = 0; i < 20; i++) begin
      pressed[0] = ((i / 3) % 2 == 1);
      tick();
    end
    pressed = '0;
    repeat (40) tick();
    chk("bounce_events", events_seen - ev0, 1);
    chk("bounce_key", last_ev_key, 1);

    // Two keys in one column, then the unused r2c3: no events, scan keeps going.
    ev0 = events_seen;
    pressed = 16'h0011;
    seen = '0;
    repeat (60) begin seen = seen | ~COL_OUT; tick(); end
    chk("double_cols_seen", seen, 4'b1111);
    pressed = '0;
    repeat (30) tick();
    pressed[2*4+3] = 1'b1;
    seen = '0;
    repeat (60) begin seen = seen | ~COL_OUT; tick(); end
    chk("unused_cols_seen", seen, 4'b1111);
    pressed = '0;
    repeat (30) tick();
    chk("no_key_events", events_seen - ev0, 0);

    // Reset during DEB_PRESS (digit 2 caught on column 1).
    do_reset();
    exp_q.push_back(key_kind(0, 1));
    pressed[1] = 1'b1;
    repeat (8) tick();
    chk("deb_col_frozen", COL_OUT, 4'b1101);
    ev0 = events_seen;
    do_reset();
    repeat (30) tick();
    chk("deb_rst_events", events_seen - ev0, 0);

    // Exact latency from reset, then reset during WAIT_REL.
    do_reset();
    exp_q.push_back(key_kind(0, 0));
    pressed[0] = 1'b1;
    n = 0;
    while (EVENT !== 1'b1 && n < 40) begin tick(); n++; end
    chk("press_latency", n, 12);
    repeat (10) tick();
    chk("wait_key_before_rst", KEY, 1);
    ev0 = events_seen;
    do_reset();
    repeat (30) tick();
    chk("wait_rst_events", events_seen - ev0, 0);
    press_release(1, 0, 30, 30);
    chk("after_rst_key", last_ev_key, 4);
    chk("after_rst_events", events_seen - ev0, 1);

    chk("pending_events", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
